robo_follower: RTL and testbench

ROBO_FOLLOWER -- requirements
Module: robo_follower

---
 rtl/robo_pkg.sv | 32 +++
 rtl/robo_follower_if.sv | 34 +++
 rtl/robo_debris_timer.sv | 33 +++
 rtl/robo_follower.sv | 188 ++++++++++++++++++
 tb/tb_robo_follower.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/robo_pkg.sv
// Shared encodings for the wall-following, debris-clearing robot controller:
// FSM state codes, debris classes, hand selection and rotation directions.
package robo_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FOLLOW   = 3'd1,
        S_SIDE_ADV = 3'd2,
        S_REMOVE   = 3'd3,
        S_DONE     = 3'd4,
        S_STUCK    = 3'd5
    } state_t;

    typedef logic [1:0] debris_t;

    localparam debris_t DEBRIS_NONE   = 2'd0;
    localparam debris_t DEBRIS_LIGHT  = 2'd1;
    localparam debris_t DEBRIS_MEDIUM = 2'd2;
    localparam debris_t DEBRIS_HEAVY  = 2'd3;

    localparam logic HAND_LEFT  = 1'b0;
    localparam logic HAND_RIGHT = 1'b1;

    localparam logic DIR_CCW = 1'b0;
    localparam logic DIR_CW  = 1'b1;

    // Turning toward the followed wall: left wall is CCW, right wall is CW.
    function automatic logic sideDir(input logic hand);
        return (hand == HAND_RIGHT) ? DIR_CW : DIR_CCW;
    endfunction

endpackage

// File: rtl/robo_follower_if.sv
// Sensor inputs and motion commands of the robot controller, bundled so the
// environment (master) and the controller (slave) share one connection.
interface robo_follower_if;
    import robo_pkg::*;

    logic       run;
    logic       step_mode;
    logic       step;
    logic       hand_sel;
    logic       head;
    logic       side;
    logic       under;
    logic       barrier;
    debris_t    debris_class;

    logic       avancar;
    logic       girar;
    logic       giro_dir;
    logic       recolher_entulho;
    logic       done;
    logic       stuck;
    logic [2:0] state_o;

    modport master (
        output run, step_mode, step, hand_sel, head, side, under, barrier, debris_class,
        input  avancar, girar, giro_dir, recolher_entulho, done, stuck, state_o
    );

    modport slave (
        input  run, step_mode, step, hand_sel, head, side, under, barrier, debris_class,
        output avancar, girar, giro_dir, recolher_entulho, done, stuck, state_o
    );

endinterface

// File: rtl/robo_debris_timer.sv
// Removal cycle counter: loads a cycle count, counts down to zero without
// wrapping, and flags zero and last-cycle conditions.
module robo_debris_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    input  logic             i_dec,
    output logic             o_zero,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);
    assign o_last = (r_count == CNT_W'(1));

endmodule

// File: rtl/robo_follower.sv
// Wall-following robot controller: follows the chosen wall, clears debris,
// detects the tube end and gives up after too many turns in place.
module robo_follower
    import robo_pkg::*;
#(
    parameter int LIGHT_CYC = 3,
    parameter int MED_CYC   = 6,
    parameter int HEAVY_CYC = 9,
    parameter int CNT_W     = 4,
    parameter int MAX_TURNS = 4
) (
    input  logic           clock,
    input  logic           reset,
    robo_follower_if.slave bus
);

    localparam int TURN_W = $clog2(MAX_TURNS + 1);

    state_t            r_state;
    state_t            w_nextState;
    logic              r_hand;
    logic              r_leftStart;
    logic [TURN_W-1:0] r_turns;

    logic r_avancar, r_girar, r_giroDir, r_recolher, r_done, r_stuck;
    logic w_avancar, w_girar, w_giroDir, w_recolher;
    logic w_decision, w_clear, w_turnLimit;
    logic w_load, w_dec, w_timerZero, w_timerLast;
    logic [CNT_W-1:0] w_loadValue;

    function automatic logic [CNT_W-1:0] classCycles(input debris_t cls);
        case (cls)
            DEBRIS_NONE, DEBRIS_LIGHT: return CNT_W'(LIGHT_CYC);
            DEBRIS_MEDIUM:             return CNT_W'(MED_CYC);
            DEBRIS_HEAVY:              return CNT_W'(HEAVY_CYC);
            default:                   return CNT_W'(LIGHT_CYC);
        endcase
    endfunction

    assign w_decision  = bus.run && (!bus.step_mode || bus.step);
    assign w_clear     = !bus.run && (r_state != S_DONE) && (r_state != S_STUCK);
    assign w_turnLimit = (r_turns >= TURN_W'(MAX_TURNS));
    assign w_loadValue = classCycles(bus.debris_class);

    robo_debris_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .i_clear(w_clear),
        .i_load (w_load),
        .i_value(w_loadValue),
        .i_dec  (w_dec),
        .o_zero (w_timerZero),
        .o_last (w_timerLast)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.run) w_nextState = S_FOLLOW;
            end
            S_FOLLOW: begin
                if (!bus.run) begin
                    w_nextState = S_IDLE;
                end else if (w_decision) begin
                    if (bus.under && r_leftStart)   w_nextState = S_DONE;
                    else if (bus.barrier)           w_nextState = S_REMOVE;
                    else if (!bus.side)             w_nextState = w_turnLimit ? S_STUCK : S_SIDE_ADV;
                    else if (bus.head && w_turnLimit) w_nextState = S_STUCK;
                end
            end
            S_SIDE_ADV: begin
                if (!bus.run)        w_nextState = S_IDLE;
                else if (w_decision) w_nextState = bus.barrier ? S_REMOVE : S_FOLLOW;
            end
            S_REMOVE: begin
                if (!bus.run) begin
                    w_nextState = S_IDLE;
                end else if (w_decision && (!bus.barrier || w_timerLast || w_timerZero)) begin
                    w_nextState = S_FOLLOW;
                end
            end
            default: w_nextState = r_state;
        endcase
    end

    // Commands for the next cycle; a turn at the limit is replaced by STUCK.
    always_comb begin
        w_avancar  = 1'b0;
        w_girar    = 1'b0;
        w_giroDir  = DIR_CCW;
        w_recolher = 1'b0;
        w_load     = 1'b0;
        w_dec      = 1'b0;
        if (w_decision) begin
            case (r_state)
                S_FOLLOW: begin
                    if (!(bus.under && r_leftStart)) begin
                        if (bus.barrier) begin
                            w_recolher = 1'b1;
                            w_load     = 1'b1;
                        end else if (!bus.side) begin
                            if (!w_turnLimit) begin
                                w_girar   = 1'b1;
                                w_giroDir = sideDir(r_hand);
                            end
                        end else if (!bus.head) begin
                            w_avancar = 1'b1;
                        end else if (!w_turnLimit) begin
                            w_girar   = 1'b1;
                            w_giroDir = !sideDir(r_hand);
                        end
                    end
                end
                S_SIDE_ADV: begin
                    if (bus.barrier) begin
                        w_recolher = 1'b1;
                        w_load     = 1'b1;
                    end else if (!bus.head) begin
                        w_avancar = 1'b1;
                    end
                end
                S_REMOVE: begin
                    if (bus.barrier) begin
                        w_dec      = 1'b1;
                        w_recolher = !(w_timerLast || w_timerZero);
                    end
                end
                default: w_avancar = 1'b0;
            endcase
        end
    end

    // Turn count, tube-end arming and hand selection all restart from IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hand      <= HAND_LEFT;
            r_leftStart <= 1'b0;
            r_turns     <= '0;
        end else if ((r_state == S_IDLE) || w_clear) begin
            r_turns     <= '0;
            r_leftStart <= 1'b0;
            if (r_state == S_IDLE) r_hand <= bus.hand_sel;
        end else if (w_avancar) begin
            r_turns     <= '0;
            r_leftStart <= 1'b1;
        end else if (w_girar && !w_turnLimit) begin
            r_turns <= r_turns + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_avancar  <= 1'b0;
            r_girar    <= 1'b0;
            r_giroDir  <= 1'b0;
            r_recolher <= 1'b0;
            r_done     <= 1'b0;
            r_stuck    <= 1'b0;
        end else begin
            r_avancar  <= w_avancar;
            r_girar    <= w_girar;
            r_giroDir  <= w_giroDir;
            r_recolher <= w_recolher;
            r_done     <= (w_nextState == S_DONE);
            r_stuck    <= (w_nextState == S_STUCK);
        end
    end

    assign bus.avancar          = r_avancar;
    assign bus.girar            = r_girar;
    assign bus.giro_dir         = r_giroDir;
    assign bus.recolher_entulho = r_recolher;
    assign bus.done             = r_done;
    assign bus.stuck            = r_stuck;
    assign bus.state_o          = r_state;

endmodule

// File: tb/tb_robo_follower.sv
// Self-checking bench for robo_follower: a directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_robo_follower;
    import robo_pkg::*;

    localparam int LIGHT_CYC = 3;
    localparam int MED_CYC   = 6;
    localparam int HEAVY_CYC = 9;
    localparam int CNT_W     = 4;
    localparam int MAX_TURNS = 4;

    typedef struct packed {
        logic       run;
        logic       stepMode;
        logic       step;
        logic       handSel;
        logic       head;
        logic       side;
        logic       under;
        logic       barrier;
        logic [1:0] cls;
    } stim_t;

    typedef struct {
        stim_t      in;
        logic [5:0] exp;
    } vec_t;

    typedef enum int { M_IDLE, M_FOLLOW, M_AFTER_TURN, M_CLEARING, M_FINISHED, M_TRAPPED } mode_t;

    // Expected outputs packed as {avancar, girar, giro_dir, recolher, done, stuck}.
    localparam logic [5:0] E_0  = 6'b000000;
    localparam logic [5:0] E_AV = 6'b100000;
    localparam logic [5:0] E_GL = 6'b010000;
    localparam logic [5:0] E_GR = 6'b011000;
    localparam logic [5:0] E_RC = 6'b000100;
    localparam logic [5:0] E_DN = 6'b000010;
    localparam logic [5:0] E_ST = 6'b000001;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checkCount = 0;
    int   passCount  = 0;

    mode_t mMode;
    logic  mHand;
    logic  mAdvanced;
    int    mTurns;
    int    mLeft;

    vec_t vecs [15];

    robo_follower_if rbIf ();

    robo_follower #(
        .LIGHT_CYC(LIGHT_CYC),
        .MED_CYC  (MED_CYC),
        .HEAVY_CYC(HEAVY_CYC),
        .CNT_W    (CNT_W),
        .MAX_TURNS(MAX_TURNS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (rbIf)
    );

    always #5 clock = ~clock;

    function automatic stim_t mk(input logic run, input logic stepMode, input logic step,
                                 input logic handSel, input logic head, input logic side,
                                 input logic under, input logic barrier, input logic [1:0] cls);
        stim_t s;
        s.run = run;   s.stepMode = stepMode; s.step = step;   s.handSel = handSel;
        s.head = head; s.side = side;         s.under = under; s.barrier = barrier;
        s.cls = cls;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        rbIf.run          = s.run;
        rbIf.step_mode    = s.stepMode;
        rbIf.step         = s.step;
        rbIf.hand_sel     = s.handSel;
        rbIf.head         = s.head;
        rbIf.side         = s.side;
        rbIf.under        = s.under;
        rbIf.barrier      = s.barrier;
        rbIf.debris_class = s.cls;
    endtask

    task automatic applyStimulus(input stim_t s);
        drive(s);
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = {rbIf.avancar, rbIf.girar, rbIf.giro_dir, rbIf.recolher_entulho, rbIf.done, rbIf.stuck};
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: {av,gi,dir,rec,done,stuck} got %b expected %b at %0t",
                      name, got, exp, $time);
    endtask

    task automatic checkState(input string name, input state_t exp);
        checkCount++;
        if (rbIf.state_o === exp) passCount++;
        else $display("[TB] FAIL %s: state_o got %0d expected %0d at %0t", name, rbIf.state_o, exp, $time);
    endtask

    task automatic resetDut(input logic hand);
        reset = 1'b0;
        drive(mk(1'b0, 1'b0, 1'b0, hand, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic startRun(input logic hand);
        resetDut(hand);
        applyStimulus(mk(1'b1, 1'b0, 1'b0, hand, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0));
    endtask

    function automatic int cyclesFor(input logic [1:0] cls);
        if (cls == 2'd2) return MED_CYC;
        if (cls == 2'd3) return HEAVY_CYC;
        return LIGHT_CYC;
    endfunction

    task automatic modelReset();
        mMode = M_IDLE; mHand = 1'b0; mAdvanced = 1'b0; mTurns = 0; mLeft = 0;
    endtask

    // Behavioural reference: one call per clock edge, returns the commands
    // that should be visible right after that edge.
    task automatic modelStep(input stim_t s, output logic [5:0] e);
        logic  av, gi, dir, rec, wantTurn, turnDir, doAdvance, doClear;
        mode_t afterTurn;
        av = 0; gi = 0; dir = 0; rec = 0; e = E_0;
        wantTurn = 0; turnDir = 0; doAdvance = 0; doClear = 0; afterTurn = M_FOLLOW;
        if (mMode == M_FINISHED) begin
            e = E_DN;
        end else if (mMode == M_TRAPPED) begin
            e = E_ST;
        end else if (mMode == M_IDLE) begin
            mHand = s.handSel; mAdvanced = 0; mTurns = 0;
            if (s.run) mMode = M_FOLLOW;
        end else if (!s.run) begin
            mMode = M_IDLE; mAdvanced = 0; mTurns = 0;
        end else if (!s.stepMode || s.step) begin
            case (mMode)
                M_FOLLOW: begin
                    if (s.under && mAdvanced) begin mMode = M_FINISHED; e = E_DN; end
                    else if (s.barrier) doClear = 1;
                    else if (!s.side) begin wantTurn = 1; turnDir = mHand; afterTurn = M_AFTER_TURN; end
                    else if (!s.head) doAdvance = 1;
                    else begin wantTurn = 1; turnDir = !mHand; afterTurn = M_FOLLOW; end
                end
                M_AFTER_TURN: begin
                    if (s.barrier) doClear = 1;
                    else begin mMode = M_FOLLOW; doAdvance = !s.head; end
                end
                M_CLEARING: begin
                    if (!s.barrier || mLeft == 0) mMode = M_FOLLOW;
                    else begin rec = 1; mLeft--; end
                end
                default: e = E_0;
            endcase
            if (wantTurn) begin
                if (mTurns >= MAX_TURNS) begin mMode = M_TRAPPED; e = E_ST; end
                else begin gi = 1; dir = turnDir; mTurns++; mMode = afterTurn; end
            end
            if (doAdvance) begin av = 1; mTurns = 0; mAdvanced = 1; end
            if (doClear) begin rec = 1; mMode = M_CLEARING; mLeft = cyclesFor(s.cls) - 1; end
            e = e | {av, gi, dir, rec, 2'b00};
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Left-hand walk: corridor (under ignored before first advance),
        // side opening, then boxed in until STUCK, which ignores everything.
        vecs[0]  = '{mk(1,0,0,0, 0,1,1,0, 2'd0), E_0};
        vecs[1]  = '{mk(1,0,0,0, 0,1,1,0, 2'd0), E_AV};
        vecs[2]  = '{mk(1,0,0,0, 0,1,0,0, 2'd0), E_AV};
        vecs[3]  = '{mk(1,0,0,0, 0,1,0,0, 2'd0), E_AV};
        vecs[4]  = '{mk(1,0,0,0, 0,1,0,0, 2'd0), E_AV};
        vecs[5]  = '{mk(1,0,0,0, 0,1,0,0, 2'd0), E_AV};
        vecs[6]  = '{mk(1,0,0,0, 0,0,0,0, 2'd0), E_GL};
        vecs[7]  = '{mk(1,0,0,0, 0,0,0,0, 2'd0), E_AV};
        vecs[8]  = '{mk(1,0,0,0, 1,1,0,0, 2'd0), E_GR};
        vecs[9]  = '{mk(1,0,0,0, 1,1,0,0, 2'd0), E_GR};
        vecs[10] = '{mk(1,0,0,0, 1,1,0,0, 2'd0), E_GR};
        vecs[11] = '{mk(1,0,0,0, 1,1,0,0, 2'd0), E_GR};
        vecs[12] = '{mk(1,0,0,0, 1,1,0,0, 2'd0), E_ST};
        vecs[13] = '{mk(1,0,0,0, 0,1,0,0, 2'd0), E_ST};
        vecs[14] = '{mk(0,0,0,0, 0,1,0,0, 2'd0), E_ST};

        drive(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        #3;
        checkOutput("resetOutputs", E_0);
        checkState("resetState", S_IDLE);

        resetDut(1'b0);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].in);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end
        checkState("boxedInState", S_STUCK);

        // Heavy debris: nine removal cycles, then a removal aborted after four.
        startRun(1'b0);
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(mk(1,0,0,0, 0,1,0,1, 2'd3));
            checkOutput($sformatf("heavy%0d", i), E_RC);
        end
        applyStimulus(mk(1,0,0,0, 0,1,0,1, 2'd3));
        checkOutput("heavyEnd", E_0);
        checkState("heavyEndState", S_FOLLOW);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(mk(1,0,0,0, 0,1,0,1, 2'd3));
            checkOutput($sformatf("abort%0d", i), E_RC);
        end
        applyStimulus(mk(1,0,0,0, 0,1,0,0, 2'd3));
        checkOutput("abortCycle5", E_0);
        checkState("abortState", S_FOLLOW);
        applyStimulus(mk(1,0,0,0, 0,1,0,0, 2'd0));
        checkOutput("afterAbortAdvance", E_AV);

        // Right-hand following; hand_sel changes after IDLE are ignored.
        startRun(1'b1);
        applyStimulus(mk(1,0,0,0, 0,0,0,0, 2'd0));
        checkOutput("rightSideTurn", E_GR);
        applyStimulus(mk(1,0,0,0, 0,0,0,0, 2'd0));
        checkOutput("rightSideAdvance", E_AV);
        applyStimulus(mk(1,0,0,0, 1,1,0,0, 2'd0));
        checkOutput("rightAwayTurn", E_GL);

        // Step mode: commands only after step pulses, removal frozen between.
        startRun(1'b0);
        for (int c = 1; c <= 8; c++) begin
            logic stepNow;
            stepNow = (c == 3) || (c == 7);
            applyStimulus(mk(1,1,stepNow,0, 0,1,0,0, 2'd0));
            checkOutput($sformatf("stepCycle%0d", c), stepNow ? E_AV : E_0);
        end
        for (int s = 1; s <= 7; s++) begin
            applyStimulus(mk(1,1,1,0, 0,1,0,1, 2'd2));
            checkOutput($sformatf("stepRemove%0d", s), (s <= 6) ? E_RC : E_0);
            if (s < 7) begin
                repeat (2) applyStimulus(mk(1,1,0,0, 0,1,0,1, 2'd2));
                checkOutput($sformatf("stepGap%0d", s), E_0);
                checkState($sformatf("stepGapState%0d", s), S_REMOVE);
            end
        end
        checkState("stepRemoveEnd", S_FOLLOW);

        // Tube end reached only once an advance has happened.
        startRun(1'b0);
        applyStimulus(mk(1,0,0,0, 0,1,1,0, 2'd0));
        checkOutput("tubeFirstAdvance", E_AV);
        applyStimulus(mk(1,0,0,0, 0,1,1,0, 2'd0));
        checkOutput("tubeEnd", E_DN);
        applyStimulus(mk(0,0,0,0, 0,1,0,0, 2'd0));
        checkOutput("tubeEndHold", E_DN);
        checkState("tubeEndState", S_DONE);

        // Asynchronous reset in the middle of a removal and of a side advance.
        startRun(1'b0);
        repeat (2) applyStimulus(mk(1,0,0,0, 0,1,0,1, 2'd3));
        checkOutput("preResetRemove", E_RC);
        #1 reset = 1'b0;
        #1;
        checkOutput("asyncResetRemove", E_0);
        checkState("asyncResetRemoveState", S_IDLE);
        startRun(1'b0);
        applyStimulus(mk(1,0,0,0, 0,0,0,0, 2'd0));
        checkOutput("preResetSideAdv", E_GL);
        #1 reset = 1'b0;
        #1;
        checkOutput("asyncResetSideAdv", E_0);
        checkState("asyncResetSideAdvState", S_IDLE);

        // Randomized episodes against the behavioural model.
        for (int ep = 0; ep < 25; ep++) begin
            logic       epStep;
            logic [5:0] expOut;
            stim_t      s;
            resetDut($urandom_range(0, 1) == 1);
            modelReset();
            epStep = (ep % 3 == 2);
            for (int c = 0; c < 40; c++) begin
                s.run      = ($urandom_range(0, 24) != 0);
                s.stepMode = epStep;
                s.step     = epStep ? ($urandom_range(0, 2) == 0) : 1'b0;
                s.handSel  = ($urandom_range(0, 1) == 1);
                s.head     = ($urandom_range(0, 1) == 1);
                s.side     = ($urandom_range(0, 3) != 0);
                s.under    = ($urandom_range(0, 9) == 0);
                s.barrier  = (mMode == M_CLEARING) ? ($urandom_range(0, 9) != 0)
                                                   : ($urandom_range(0, 9) == 0);
                s.cls      = 2'($urandom_range(0, 3));
                applyStimulus(s);
                modelStep(s, expOut);
                checkOutput($sformatf("random ep%0d cyc%0d", ep, c), expOut);
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
